// File: rtl/param_onehot_decoder_seq.sv
// Registered N-to-OUT_W one-hot decoder with load/hold and an auto-scan that walks the select.
// Define DECODER_ACTIVE_LOW_EN for an active-low one-hot out (idle value all ones).
module param_onehot_decoder_seq #(
    parameter int SEL_W       = 5,
    parameter int OUT_W       = 1 << SEL_W,
    parameter int STEP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    input  logic             scan,
    input  logic             scan_dir,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             active,
    output logic             wrap,
    output logic             err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OUT_IDLE = '1;
    localparam logic [OUT_W-1:0] OUT_INV  = '1;
`else
    localparam logic [OUT_W-1:0] OUT_IDLE = '0;
    localparam logic [OUT_W-1:0] OUT_INV  = '0;
`endif

    // Wrap point is OUT_W-1, not the top of the index range, so partial decoders stay legal.
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
    localparam logic [15:0]      CNT_LAST = 16'(STEP_CYCLES - 1);

    logic [1:0]       state, state_n;
    logic [SEL_W-1:0] idx_n;
    logic [15:0]      cnt, cnt_n;
    logic             wrap_n, err_n;
    logic [OUT_W-1:0] onehot;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (clear) begin
            state_n = IDLE;
        end else if (load) begin
            if (32'(sel) >= OUT_W) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else begin
                state_n = HOLD;
                idx_n   = sel;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (scan) begin
                        state_n = SCAN;
                        cnt_n   = '0;
                    end
                end
                SCAN: begin
                    if (!scan) begin
                        state_n = HOLD;
                    end else if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if (!scan_dir) begin
                            wrap_n = (idx == IDX_LAST);
                            idx_n  = wrap_n ? '0 : idx + 1'b1;
                        end else begin
                            wrap_n = (idx == '0);
                            idx_n  = wrap_n ? IDX_LAST : idx - 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << idx_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            out    <= OUT_IDLE;
            active <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else if (en) begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            out    <= (state_n == IDLE) ? OUT_IDLE : (onehot ^ OUT_INV);
            active <= (state_n != IDLE);
            wrap   <= wrap_n;
            err    <= err_n;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_onehot_decoder_seq.sv
// Bench for param_onehot_decoder_seq: a full 32-output/1-step instance and a 20-output/3-step
// instance share random stimulus and are compared every cycle against an integer model.
module tb_param_onehot_decoder_seq;
    logic       clk = 1'b0;
    logic       rst, en, clear, load, scan, scan_dir;
    logic [4:0] sel;

    logic [31:0] out1;
    logic [4:0]  idx1;
    logic        active1, wrap1, err1;
    logic [19:0] out2;
    logic [4:0]  idx2;
    logic        active2, wrap2, err2;

    always #5 clk = ~clk;

    param_onehot_decoder_seq #(.SEL_W(5), .OUT_W(32), .STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load), .sel(sel),
        .scan(scan), .scan_dir(scan_dir), .out(out1), .idx(idx1),
        .active(active1), .wrap(wrap1), .err(err1)
    );

    param_onehot_decoder_seq #(.SEL_W(5), .OUT_W(20), .STEP_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load), .sel(sel),
        .scan(scan), .scan_dir(scan_dir), .out(out2), .idx(idx2),
        .active(active2), .wrap(wrap2), .err(err2)
    );

`ifdef DECODER_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    typedef struct {
        int mode;   // 0 idle, 1 hold, 2 scan
        int idx;
        int cnt;
        bit wrap;
        bit err;
    } mdl_t;

    mdl_t m1, m2;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = 0; r.idx = 0; r.cnt = 0; r.wrap = 1'b0; r.err = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int ow, int steps);
        mdl_t r;
        int   nxt;
        r = m;
        r.wrap = 1'b0;
        r.err  = 1'b0;
        if (!en) return r;
        if (clear) r.mode = 0;
        else if (load) begin
            if (int'(sel) >= ow) begin r.mode = 0; r.err = 1'b1; end
            else begin r.mode = 1; r.idx = int'(sel); end
        end else if (m.mode == 1 && scan) begin
            r.mode = 2; r.cnt = 0;
        end else if (m.mode == 2) begin
            if (!scan) r.mode = 1;
            else if (m.cnt + 1 < steps) r.cnt = m.cnt + 1;
            else begin
                r.cnt  = 0;
                nxt    = scan_dir ? m.idx - 1 : m.idx + 1;
                r.wrap = (nxt < 0) || (nxt >= ow);
                r.idx  = (nxt + ow) % ow;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] mout(mdl_t m, int ow);
        logic [63:0] v, mask;
        mask = (64'd1 << ow) - 64'd1;
        v = (m.mode == 0) ? 64'd0 : (64'd1 << m.idx);
        return ACT_LOW ? (~v & mask) : v;
    endfunction

    task automatic check_all();
        chk("out1",    64'(out1),    mout(m1, 32));
        chk("idx1",    64'(idx1),    64'(m1.idx));
        chk("active1", 64'(active1), 64'(m1.mode != 0));
        chk("wrap1",   64'(wrap1),   64'(m1.wrap));
        chk("err1",    64'(err1),    64'(m1.err));
        chk("out2",    64'(out2),    mout(m2, 20));
        chk("idx2",    64'(idx2),    64'(m2.idx));
        chk("active2", 64'(active2), 64'(m2.mode != 0));
        chk("wrap2",   64'(wrap2),   64'(m2.wrap));
        chk("err2",    64'(err2),    64'(m2.err));
    endtask

    // Inputs change only after the falling edge; model advances on the rising edge.
    task automatic tick();
        @(posedge clk);
        m1 = mstep(m1, 32, 1);
        m2 = mstep(m2, 20, 3);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit e, input bit c, input bit l, input int s, input bit sc,
                         input bit d, input int n);
        en = e; clear = c; load = l; sel = 5'(s); scan = sc; scan_dir = d;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; sel = '0; scan = 1'b0; scan_dir = 1'b0;
        m1 = mreset(); m2 = mreset();
        @(negedge clk);
        check_all();
        chk("rst_out1", 64'(out1), ACT_LOW ? 64'hFFFF_FFFF : 64'd0);
        rst = 1'b0;

        drive(1, 0, 1, 13, 0, 0, 1);
        chk("ld13_out1", 64'(out1), ACT_LOW ? 64'hFFFF_DFFF : 64'h0000_2000);
        drive(1, 0, 0, 0, 0, 0, 10);
        chk("ld13_held", 64'(idx1), 64'd13);

        drive(1, 0, 1, 30, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 1);
        chk("scan31", 64'(idx1), 64'd31);
        drive(1, 0, 0, 0, 1, 0, 1);
        chk("wrap0", 64'({idx1, wrap1}), 64'({5'd0, 1'b1}));
        drive(1, 0, 0, 0, 1, 0, 1);
        chk("scan1", 64'({idx1, wrap1}), 64'({5'd1, 1'b0}));
        drive(1, 0, 0, 0, 0, 0, 2);

        drive(1, 0, 1, 25, 0, 0, 1);
        chk("err20", 64'({err2, active2, out2}), 64'({1'b1, 1'b0, ACT_LOW ? 20'hFFFFF : 20'h0}));
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 1, 4);
        chk("wrap19", 64'({idx2, wrap2}), 64'({5'd19, 1'b1}));
        drive(1, 0, 0, 0, 1, 1, 3);

        drive(1, 0, 1, 4, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 3);
        drive(0, 0, 1, 9, 1, 0, 5);
        chk("en_freeze", 64'(idx2), 64'd4);
        drive(1, 0, 0, 0, 1, 0, 1);
        chk("step3", 64'(idx2), 64'd5);
        drive(1, 0, 0, 0, 1, 0, 6);
        drive(1, 0, 1, 2, 1, 0, 1);
        chk("load_wins", 64'({idx2, active2}), 64'({5'd2, 1'b1}));
        drive(1, 1, 0, 0, 1, 0, 1);

        drive(1, 0, 1, 18, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 4);
        #2 rst = 1'b1;
        m1 = mreset(); m2 = mreset();
        #1;
        chk("async_rst", 64'({out1, idx1, active1}), 64'({ACT_LOW ? 32'hFFFF_FFFF : 32'h0, 5'd0, 1'b0}));
        @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(99) < 88);
            clear    = ($urandom_range(99) < 3);
            load     = ($urandom_range(99) < 10);
            sel      = 5'($urandom_range(31));
            scan     = ($urandom_range(99) < 75);
            scan_dir = ($urandom_range(99) < 40);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
